game_frame_scheduler: RTL and testbench

Frame-synchronous controller for the game-object datapath between the keypad driver and the VGA draw stage. Once per video frame, during vertical blanking, it latches the current keypad command and runs a fixed update sequence: move the player, service a fire request, then advance the bullet. It commits all object positions together, so the `draw_square` instances never see a half-updated frame. It replaces the free-running per-key position registers with a single sequenced, bounds-checked update path.

---
 rtl/game_pkg.sv | 24 ++
 rtl/edge_rise.sv | 18 +
 rtl/game_frame_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_game_frame_scheduler.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and key codes for the game-object datapath.
// Used by the frame scheduler and the draw stage.
package game_pkg;

   typedef enum logic [2:0] {IDLE, LATCH, MOVE, FIRE, BULLET, COMMIT} sched_state_t;

   typedef logic [10:0] coord_t;

   typedef struct packed {
      coord_t x;
      coord_t y;
      logic   active;
   } obj_t;

   localparam logic [3:0] KEY_UP   = 4'h5;
   localparam logic [3:0] KEY_DOWN = 4'h0;
   localparam logic [3:0] KEY_FIRE = 4'hA;

   // Bound checks run one bit wider so a coordinate plus an offset cannot wrap.
   function automatic logic [11:0] widen(input coord_t c);
      return {1'b0, c};
   endfunction

endpackage

// File: rtl/edge_rise.sv
// Registered rising-edge detector: pulses in the first cycle sig_i is seen high.
module edge_rise (
   input  logic clk,
   input  logic reset_tv,
   input  logic sig_i,
   output logic rise_o
);

   logic sig_q;

   always_ff @(posedge clk) begin
      if (reset_tv) sig_q <= 1'b0;
      else          sig_q <= sig_i;
   end

   assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/game_frame_scheduler.sv
// Once-per-frame player/bullet update sequencer; all positions commit together
// in one cycle so the draw stage never sees a half-updated frame.
module game_frame_scheduler #(
   parameter int         X_MAX    = 640,
   parameter int         Y_MAX    = 480,
   parameter int         Y_MARGIN = 50,
   parameter int         P_X      = 100,
   parameter int         P_Y0     = 100,
   parameter int         P_W      = 50,
   parameter int         P_H      = 100,
   parameter int         VEL      = 1,
   parameter int         BUL_VEL  = 4,
   parameter logic [3:0] KEY_UP   = game_pkg::KEY_UP,
   parameter logic [3:0] KEY_DOWN = game_pkg::KEY_DOWN,
   parameter logic [3:0] KEY_FIRE = game_pkg::KEY_FIRE
) (
   input  logic        clk,
   input  logic        reset_tv,
   input  logic        vsync,
   input  logic        key_valid,
   input  logic [3:0]  key_code,
   output logic [10:0] pos_x,
   output logic [10:0] pos_y,
   output logic [10:0] bul_x,
   output logic [10:0] bul_y,
   output logic        bul_active,
   output logic        busy,
   output logic        frame_done,
   output logic        overrun
);

   import game_pkg::*;

   localparam logic [11:0] UP_MIN    = 12'(Y_MARGIN + VEL);
   localparam logic [11:0] DOWN_OFS  = 12'(P_H + VEL);
   localparam logic [11:0] Y_LIMIT   = 12'(Y_MAX);
   localparam logic [11:0] BUL_OFS   = 12'(BUL_VEL);
   localparam logic [11:0] X_LIMIT   = 12'(X_MAX);
   localparam coord_t      VEL_C     = 11'(VEL);
   localparam coord_t      BUL_VEL_C = 11'(BUL_VEL);
   localparam coord_t      SPAWN_X   = 11'(P_X + P_W);
   localparam coord_t      HALF_H    = 11'(P_H / 2);
   localparam coord_t      PLAYER_X  = 11'(P_X);
   localparam coord_t      PLAYER_Y0 = 11'(P_Y0);

   logic frame_tick;
   logic key_rise;
   logic fire_edge;

   sched_state_t state_q, state_d;
   logic         cmd_valid_q, cmd_valid_d;
   logic [3:0]   cmd_code_q, cmd_code_d;
   logic         fire_pend_q, fire_pend_d;
   logic         spawned_q, spawned_d;
   coord_t       sh_y_q, sh_y_d;
   obj_t         sh_bul_q, sh_bul_d;
   coord_t       out_y_q, out_y_d;
   obj_t         out_bul_q, out_bul_d;
   logic         frame_done_q, frame_done_d;
   logic         overrun_q, overrun_d;

   edge_rise u_vsync_edge (
      .clk      (clk),
      .reset_tv (reset_tv),
      .sig_i    (vsync),
      .rise_o   (frame_tick)
   );

   edge_rise u_key_edge (
      .clk      (clk),
      .reset_tv (reset_tv),
      .sig_i    (key_valid),
      .rise_o   (key_rise)
   );

   assign fire_edge = key_rise && (key_code == KEY_FIRE);

   always_comb begin
      // NOTE: every _d starts from its _q so no branch below can infer a latch.
      state_d      = state_q;
      cmd_valid_d  = cmd_valid_q;
      cmd_code_d   = cmd_code_q;
      fire_pend_d  = fire_pend_q;
      spawned_d    = spawned_q;
      sh_y_d       = sh_y_q;
      sh_bul_d     = sh_bul_q;
      out_y_d      = out_y_q;
      out_bul_d    = out_bul_q;
      frame_done_d = 1'b0;
      overrun_d    = overrun_q;

      case (state_q)
         IDLE: begin
            if (frame_tick) state_d = LATCH;
         end
         LATCH: begin
            cmd_valid_d = key_valid;
            cmd_code_d  = key_code;
            sh_y_d      = out_y_q;
            sh_bul_d    = out_bul_q;
            spawned_d   = 1'b0;
            state_d     = MOVE;
         end
         MOVE: begin
            if (cmd_valid_q) begin
               if (cmd_code_q == KEY_UP) begin
                  if (widen(sh_y_q) >= UP_MIN) sh_y_d = sh_y_q - VEL_C;
               end else if (cmd_code_q == KEY_DOWN) begin
                  if (widen(sh_y_q) + DOWN_OFS <= Y_LIMIT) sh_y_d = sh_y_q + VEL_C;
               end
            end
            state_d = FIRE;
         end
         FIRE: begin
            // A request against a live bullet is dropped, not queued.
            if (fire_pend_q) begin
               fire_pend_d = 1'b0;
               if (!sh_bul_q.active) begin
                  sh_bul_d.active = 1'b1;
                  sh_bul_d.x      = SPAWN_X;
                  sh_bul_d.y      = sh_y_q + HALF_H;
                  spawned_d       = 1'b1;
               end
            end
            state_d = BULLET;
         end
         BULLET: begin
            if (sh_bul_q.active && !spawned_q) begin
               if (widen(sh_bul_q.x) + BUL_OFS >= X_LIMIT) sh_bul_d.active = 1'b0;
               else                                        sh_bul_d.x      = sh_bul_q.x + BUL_VEL_C;
            end
            state_d = COMMIT;
         end
         COMMIT: begin
            out_y_d      = sh_y_q;
            out_bul_d    = sh_bul_q;
            frame_done_d = 1'b1;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // A new fire edge outranks the FIRE-state clear, so it is served next frame.
      if (fire_edge) fire_pend_d = 1'b1;
      if (frame_tick && (state_q != IDLE)) overrun_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      // NOTE: reset is synchronous and aborts any partial sequence on the same edge;
      // non-blocking assignments keep every register reading pre-edge values.
      if (reset_tv) begin
         state_q      <= IDLE;
         cmd_valid_q  <= 1'b0;
         cmd_code_q   <= 4'h0;
         fire_pend_q  <= 1'b0;
         spawned_q    <= 1'b0;
         sh_y_q       <= PLAYER_Y0;
         sh_bul_q     <= '0;
         out_y_q      <= PLAYER_Y0;
         out_bul_q    <= '0;
         frame_done_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cmd_valid_q  <= cmd_valid_d;
         cmd_code_q   <= cmd_code_d;
         fire_pend_q  <= fire_pend_d;
         spawned_q    <= spawned_d;
         sh_y_q       <= sh_y_d;
         sh_bul_q     <= sh_bul_d;
         out_y_q      <= out_y_d;
         out_bul_q    <= out_bul_d;
         frame_done_q <= frame_done_d;
         overrun_q    <= overrun_d;
      end
   end

   assign pos_x      = PLAYER_X;
   assign pos_y      = out_y_q;
   assign bul_x      = out_bul_q.x;
   assign bul_y      = out_bul_q.y;
   assign bul_active = out_bul_q.active;
   assign busy       = (state_q != IDLE);
   assign frame_done = frame_done_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_game_frame_scheduler.sv
// Scoreboard bench for game_frame_scheduler: a behavioural model pushes the
// expected commit for each frame, popped when frame_done pulses.
module tb_game_frame_scheduler;

   logic        clk = 1'b0;
   logic        reset_tv = 1'b1;
   logic        vsync = 1'b0;
   logic        key_valid = 1'b0;
   logic [3:0]  key_code = 4'h0;
   logic [10:0] pos_x, pos_y, bul_x, bul_y;
   logic        bul_active, busy, frame_done, overrun;

   int checks = 0;
   int fails  = 0;

   typedef struct {
      int y;
      int bx;
      int by;
      bit ba;
   } exp_t;

   exp_t exp_q[$];

   int   m_y, m_bx, m_by;
   bit   m_ba, m_pend;
   logic kv_prev;

   always #5 clk = ~clk;

   game_frame_scheduler dut (
      .clk        (clk),
      .reset_tv   (reset_tv),
      .vsync      (vsync),
      .key_valid  (key_valid),
      .key_code   (key_code),
      .pos_x      (pos_x),
      .pos_y      (pos_y),
      .bul_x      (bul_x),
      .bul_y      (bul_y),
      .bul_active (bul_active),
      .busy       (busy),
      .frame_done (frame_done),
      .overrun    (overrun)
   );

   task automatic model_reset();
      m_y = 100; m_bx = 0; m_by = 0; m_ba = 0; m_pend = 0; kv_prev = 1'b0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset_tv = 1'b1; vsync = 1'b0; key_valid = 1'b0; key_code = 4'h0;
      repeat (2) @(negedge clk);
      reset_tv = 1'b0;
      model_reset();
   endtask

   task automatic set_key(input logic kv, input logic [3:0] kc);
      @(negedge clk);
      if (kv && !kv_prev && kc == 4'hA) m_pend = 1;
      key_valid = kv; key_code = kc; kv_prev = kv;
   endtask

   task automatic model_frame(input logic kv, input logic [3:0] kc);
      exp_t e;
      bit   sp;
      if (kv && kc == 4'h5 && m_y >= 51) m_y = m_y - 1;
      else if (kv && kc == 4'h0 && m_y + 101 <= 480) m_y = m_y + 1;
      sp = 0;
      if (m_pend) begin
         m_pend = 0;
         if (!m_ba) begin m_ba = 1; m_bx = 150; m_by = m_y + 50; sp = 1; end
      end
      if (m_ba && !sp) begin
         if (m_bx + 4 >= 640) m_ba = 0;
         else m_bx = m_bx + 4;
      end
      e.y = m_y; e.bx = m_bx; e.by = m_by; e.ba = m_ba;
      exp_q.push_back(e);
   endtask

   task automatic start_frame();
      @(negedge clk) vsync = 1'b0;
      @(negedge clk) vsync = 1'b1;
   endtask

   task automatic wait_commit(input string name);
      int   cnt;
      exp_t e;
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (!frame_done && cnt < 20);
      if (!frame_done) begin
         checks++; fails++;
         $display("FAIL %s: no frame_done within %0d cycles", name, cnt);
         if (exp_q.size() != 0) void'(exp_q.pop_front());
      end else begin
         e = exp_q.pop_front();
         checks++;
         if (pos_y !== 11'(e.y)) begin
            fails++; $display("FAIL %s pos_y: got %0d want %0d", name, pos_y, e.y);
         end
         checks++;
         if (bul_x !== 11'(e.bx)) begin
            fails++; $display("FAIL %s bul_x: got %0d want %0d", name, bul_x, e.bx);
         end
         checks++;
         if (bul_y !== 11'(e.by)) begin
            fails++; $display("FAIL %s bul_y: got %0d want %0d", name, bul_y, e.by);
         end
         checks++;
         if (bul_active !== e.ba) begin
            fails++; $display("FAIL %s bul_active: got %0b want %0b", name, bul_active, e.ba);
         end
         checks++;
         if (pos_x !== 11'd100) begin
            fails++; $display("FAIL %s pos_x: got %0d want 100", name, pos_x);
         end
      end
   endtask

   task automatic run_frame(input logic kv, input logic [3:0] kc, input string name);
      set_key(kv, kc);
      model_frame(kv, kc);
      start_frame();
      wait_commit(name);
   endtask

   task automatic test_reset();
      logic [47:0] obs;
      apply_reset();
      obs = {pos_x, pos_y, bul_x, bul_y, bul_active, busy, frame_done, overrun};
      checks++;
      if (obs !== {11'd100, 11'd100, 11'd0, 11'd0, 4'b0000}) begin
         fails++; $display("FAIL reset_state: got %h want %h", obs, {11'd100, 11'd100, 11'd0, 11'd0, 4'b0000});
      end
   endtask

   task automatic test_idle_frame();
      int   busy_n, pulses, first;
      exp_t e;
      busy_n = 0; pulses = 0; first = 0;
      set_key(1'b0, 4'h0);
      model_frame(1'b0, 4'h0);
      start_frame();
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (busy) busy_n++;
         if (frame_done) begin
            pulses++;
            if (pulses == 1) begin
               first = c;
               e = exp_q.pop_front();
               checks++;
               if (pos_y !== 11'(e.y) || bul_active !== e.ba) begin
                  fails++; $display("FAIL idle_frame outputs: pos_y=%0d act=%0b want %0d/%0b", pos_y, bul_active, e.y, e.ba);
               end
            end
         end
      end
      if (pulses == 0 && exp_q.size() != 0) void'(exp_q.pop_front());
      checks++;
      if (first != 6) begin fails++; $display("FAIL frame_done_latency: got %0d want 6", first); end
      checks++;
      if (pulses != 1) begin fails++; $display("FAIL frame_done_pulses: got %0d want 1", pulses); end
      checks++;
      if (busy_n != 5) begin fails++; $display("FAIL busy_cycles: got %0d want 5", busy_n); end
   endtask

   task automatic test_up_clamp();
      for (int i = 0; i < 60 && m_y > 51; i++) run_frame(1'b1, 4'h5, "up_step");
      checks++;
      if (pos_y !== 11'd51) begin fails++; $display("FAIL up_reach51: got %0d want 51", pos_y); end
      for (int i = 0; i < 3; i++) run_frame(1'b1, 4'h5, "up_clamp");
      checks++;
      if (pos_y !== 11'd50) begin fails++; $display("FAIL up_clamp50: got %0d want 50", pos_y); end
   endtask

   task automatic test_down_clamp();
      for (int i = 0; i < 400 && m_y < 379; i++) run_frame(1'b1, 4'h0, "down_step");
      checks++;
      if (pos_y !== 11'd379) begin fails++; $display("FAIL down_reach379: got %0d want 379", pos_y); end
      for (int i = 0; i < 2; i++) run_frame(1'b1, 4'h0, "down_clamp");
      checks++;
      if (pos_y !== 11'd380) begin fails++; $display("FAIL down_clamp380: got %0d want 380", pos_y); end
   endtask

   task automatic test_fire();
      apply_reset();
      run_frame(1'b1, 4'hA, "fire_spawn");
      checks++;
      if ({bul_active, bul_x, bul_y} !== {1'b1, 11'd150, 11'd150}) begin
         fails++; $display("FAIL fire_spawn_abs: got act=%0b x=%0d y=%0d want 1/150/150", bul_active, bul_x, bul_y);
      end
      run_frame(1'b0, 4'h0, "bul_move");
      checks++;
      if (bul_x !== 11'd154) begin fails++; $display("FAIL bul_move_abs: got %0d want 154", bul_x); end
      run_frame(1'b1, 4'hA, "refire_alive");
      checks++;
      if ({bul_active, bul_x, bul_y} !== {1'b1, 11'd158, 11'd150}) begin
         fails++; $display("FAIL refire_alive_abs: got act=%0b x=%0d y=%0d want 1/158/150", bul_active, bul_x, bul_y);
      end
   endtask

   task automatic test_bullet_edge();
      for (int i = 0; i < 200 && m_bx < 634; i++) run_frame(1'b0, 4'h0, "bul_fly");
      checks++;
      if (bul_x !== 11'd634) begin fails++; $display("FAIL bul_reach634: got %0d want 634", bul_x); end
      run_frame(1'b1, 4'hA, "edge_hold1");
      run_frame(1'b1, 4'hA, "edge_hold2");
      checks++;
      if ({bul_active, bul_x} !== {1'b0, 11'd638}) begin
         fails++; $display("FAIL bul_expire: got act=%0b x=%0d want 0/638", bul_active, bul_x);
      end
      run_frame(1'b1, 4'hA, "edge_hold3");
      checks++;
      if (bul_active !== 1'b0) begin fails++; $display("FAIL held_no_refire: got %0b want 0", bul_active); end
      run_frame(1'b0, 4'h0, "release");
      run_frame(1'b1, 4'hA, "repress");
      checks++;
      if ({bul_active, bul_x} !== {1'b1, 11'd150}) begin
         fails++; $display("FAIL repress_spawn: got act=%0b x=%0d want 1/150", bul_active, bul_x);
      end
   endtask

   task automatic test_reset_mid();
      logic [47:0] obs;
      int          pulses;
      set_key(1'b1, 4'h5);
      start_frame();
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin fails++; $display("FAIL mid_busy: got %0b want 1", busy); end
      reset_tv = 1'b1; vsync = 1'b0;
      @(negedge clk);
      obs = {pos_x, pos_y, bul_x, bul_y, bul_active, busy, frame_done, overrun};
      checks++;
      if (obs !== {11'd100, 11'd100, 11'd0, 11'd0, 4'b0000}) begin
         fails++; $display("FAIL mid_reset_state: got %h want %h", obs, {11'd100, 11'd100, 11'd0, 11'd0, 4'b0000});
      end
      reset_tv = 1'b0; key_valid = 1'b0;
      model_reset();
      pulses = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (frame_done) pulses++;
      end
      checks++;
      if (pulses != 0) begin fails++; $display("FAIL mid_no_commit: got %0d pulses want 0", pulses); end
   endtask

   task automatic test_overrun();
      int pulses;
      checks++;
      if (overrun !== 1'b0) begin fails++; $display("FAIL overrun_clear: got %0b want 0", overrun); end
      set_key(1'b0, 4'h0);
      model_frame(1'b0, 4'h0);
      start_frame();
      @(negedge clk) vsync = 1'b0;
      @(negedge clk) vsync = 1'b1;
      wait_commit("overrun_frame");
      checks++;
      if (overrun !== 1'b1) begin fails++; $display("FAIL overrun_set: got %0b want 1", overrun); end
      pulses = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (frame_done) pulses++;
      end
      checks++;
      if (pulses != 0) begin fails++; $display("FAIL overrun_tick_ignored: got %0d pulses want 0", pulses); end
      run_frame(1'b0, 4'h0, "after_overrun");
      checks++;
      if (overrun !== 1'b1) begin fails++; $display("FAIL overrun_sticky: got %0b want 1", overrun); end
      apply_reset();
      checks++;
      if (overrun !== 1'b0) begin fails++; $display("FAIL overrun_reset: got %0b want 0", overrun); end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_idle_frame();
      test_up_clamp();
      test_down_clamp();
      test_fire();
      test_bullet_edge();
      test_reset_mid();
      test_overrun();
      checks++;
      if (exp_q.size() != 0) begin
         fails++; $display("FAIL scoreboard_drain: %0d entries left want 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
